// File: rtl/gps_clk_pkg.sv
// Shared types and default constants for the GPS-disciplined clock blocks.
package gps_clk_pkg;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_NOMINAL = 50_000_000;
  localparam int DEF_TOL     = 5_000;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } pps_state_e;

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser for the asynchronous PPS input plus a delay flop for
// rising-edge detection.
module pps_sync_edge (
  input  logic clock,
  input  logic rst,
  input  logic pps_in,
  output logic pps_edge
);

  // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (edge-detect delay)
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pps_in};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pps_edge = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pps_tick_gen.sv
// Disciplined 1 Hz tick generator: measures the PPS period, locks after
// consecutive good periods, and freewheels at the last good period in holdover.
module pps_tick_gen
  import gps_clk_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int NOMINAL      = DEF_NOMINAL,
  parameter int TOL          = DEF_TOL,
  parameter int PULSE_W      = 5_000_000,
  parameter int LOCK_COUNT   = 3,
  parameter int HOLDOVER_MAX = 60
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             pps_in,
  output logic             tick_1hz,
  output logic             tick_stb,
  output logic [CNT_W-1:0] period_out,
  output logic             locked,
  output logic             holdover,
  output logic             pps_err
);

  localparam int PW     = CNT_W + 1;
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int HO_W   = $clog2(HOLDOVER_MAX + 1);

  localparam logic [CNT_W-1:0]  NOM_C     = CNT_W'(NOMINAL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0]  PULSE_C   = CNT_W'(PULSE_W);
  localparam logic [PW-1:0]     PER_MIN   = PW'(NOMINAL - TOL);
  localparam logic [PW-1:0]     PER_MAX   = PW'(NOMINAL + TOL);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);
  localparam logic [HO_W-1:0]   HO_MAX_C  = HO_W'(HOLDOVER_MAX);

  logic pps_edge;

  pps_sync_edge u_sync (
    .clock    (clock),
    .rst      (rst),
    .pps_in   (pps_in),
    .pps_edge (pps_edge)
  );

  pps_state_e        state_q, state_d;
  logic [CNT_W-1:0]  meas_cnt_q, meas_cnt_d;
  logic [CNT_W-1:0]  gen_cnt_q, gen_cnt_d;
  logic [CNT_W-1:0]  gen_period_q, gen_period_d;
  logic [CNT_W-1:0]  period_out_q, period_out_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
  logic              have_prev_q, have_prev_d;
  logic              tick_1hz_q, tick_1hz_d;
  logic              tick_stb_q, tick_stb_d;
  logic              pps_err_q, pps_err_d;

  // One extra bit so a saturated counter yields a period beyond any window.
  logic [PW-1:0]     period;
  logic              valid;
  logic              timeout;
  logic              gen_last;
  logic [GOOD_W-1:0] good_inc;
  logic              realign;
  logic              gen_on;

  assign period   = {1'b0, meas_cnt_q} + PW'(1);
  assign valid    = pps_edge & have_prev_q & (period >= PER_MIN) & (period <= PER_MAX);
  assign timeout  = have_prev_q & ~pps_edge & (meas_cnt_q == TIMEOUT_C);
  assign gen_last = gen_cnt_q >= (gen_period_q - 1'b1);
  assign good_inc = good_cnt_q + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    have_prev_d  = have_prev_q | pps_edge;
    good_cnt_d   = good_cnt_q;
    ho_cnt_d     = ho_cnt_q;
    gen_period_d = gen_period_q;
    period_out_d = period_out_q;
    gen_cnt_d    = gen_last ? '0 : gen_cnt_q + 1'b1;
    meas_cnt_d   = pps_edge ? '0 : (&meas_cnt_q ? meas_cnt_q : meas_cnt_q + 1'b1);
    pps_err_d    = pps_edge & have_prev_q & ~valid;
    realign      = 1'b0;

    if (valid) begin
      gen_period_d = period[CNT_W-1:0];
      period_out_d = period[CNT_W-1:0];
    end

    case (state_q)
      UNLOCKED: begin
        if (pps_edge) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (valid) begin
          if (good_inc == LOCK_C) begin
            state_d = LOCKED;
            realign = 1'b1;
          end else begin
            good_cnt_d = good_inc;
          end
        end else if (pps_edge) begin
          good_cnt_d = '0;
        end else if (timeout) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (valid) begin
          realign = 1'b1;
        end else if (pps_edge || timeout) begin
          state_d  = HOLDOVER;
          ho_cnt_d = '0;
        end
      end
      HOLDOVER: begin
        if (valid) begin
          state_d = LOCKED;
          realign = 1'b1;
        end else if (ho_cnt_q >= HO_MAX_C) begin
          state_d = UNLOCKED;
        end else if (gen_last) begin
          ho_cnt_d = ho_cnt_q + 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    if (state_d == UNLOCKED && state_q != UNLOCKED) begin
      have_prev_d = 1'b0;
      good_cnt_d  = '0;
      ho_cnt_d    = '0;
    end

    // Realign and natural wrap both land on zero, so they share one strobe.
    if (realign) begin
      gen_cnt_d = '0;
    end

    gen_on     = (state_d == LOCKED) || (state_d == HOLDOVER);
    tick_stb_d = gen_on & (gen_cnt_d == '0);
    tick_1hz_d = gen_on & (gen_cnt_d < PULSE_C);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      meas_cnt_q   <= '0;
      gen_cnt_q    <= '0;
      gen_period_q <= NOM_C;
      period_out_q <= NOM_C;
      good_cnt_q   <= '0;
      ho_cnt_q     <= '0;
      have_prev_q  <= 1'b0;
      tick_1hz_q   <= 1'b0;
      tick_stb_q   <= 1'b0;
      pps_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      meas_cnt_q   <= meas_cnt_d;
      gen_cnt_q    <= gen_cnt_d;
      gen_period_q <= gen_period_d;
      period_out_q <= period_out_d;
      good_cnt_q   <= good_cnt_d;
      ho_cnt_q     <= ho_cnt_d;
      have_prev_q  <= have_prev_d;
      tick_1hz_q   <= tick_1hz_d;
      tick_stb_q   <= tick_stb_d;
      pps_err_q    <= pps_err_d;
    end
  end

  assign tick_1hz   = tick_1hz_q;
  assign tick_stb   = tick_stb_q;
  assign period_out = period_out_q;
  assign pps_err    = pps_err_q;
  assign locked     = (state_q == LOCKED);
  assign holdover   = (state_q == HOLDOVER);

endmodule
